// File: rtl/multi_digit_code_converter.sv
// Converts a multi-digit 8421 BCD word into 8421, 2421 (Aiken), excess-3 or Gray code.
// Conversion runs one digit per clock. Input and output use valid/ready handshakes.
module multi_digit_code_converter #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   in_data,
    input  logic [1:0]            in_mode,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   out_data,
    output logic [DIGITS-1:0]     out_err,
    output logic                  busy
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [4*DIGITS-1:0]   data_q, data_d;
    logic [1:0]            mode_q, mode_d;
    logic [4*DIGITS-1:0]   out_data_q, out_data_d;
    logic [DIGITS-1:0]     out_err_q, out_err_d;

    logic [3:0]            cur_digit;
    logic [4:0]            cur_conv;

    // Returns {err, code}. Any non-BCD digit yields code 0000 and err set.
    function automatic logic [4:0] conv_digit(input logic [3:0] d, input logic [1:0] m);
        logic [3:0] code;
        if (d > 4'd9) begin
            return 5'b1_0000;
        end
        case (m)
            2'd1:    code = (d < 4'd5) ? d : d + 4'd6;
            2'd2:    code = d + 4'd3;
            2'd3:    code = d ^ (d >> 1);
            default: code = d;
        endcase
        return {1'b0, code};
    endfunction

    // NOTE: every variable written here gets a default first, so no latch is inferred.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        data_d     = data_q;
        mode_d     = mode_q;
        out_data_d = out_data_q;
        out_err_d  = out_err_q;

        cur_digit = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) cur_digit = data_q[4*i +: 4];
        end
        cur_conv = conv_digit(cur_digit, mode_q);

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    data_d     = in_data;
                    mode_d     = in_mode;
                    idx_d      = '0;
                    out_data_d = '0;
                    out_err_d  = '0;
                    state_d    = CONV;
                end
            end
            CONV: begin
                for (int i = 0; i < DIGITS; i++) begin
                    if (idx_q == IDX_W'(i)) begin
                        out_data_d[4*i +: 4] = cur_conv[3:0];
                        out_err_d[i]         = cur_conv[4];
                    end
                end
                if (idx_q == LAST_IDX) state_d = DONE;
                else                   idx_d   = idx_q + IDX_W'(1);
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            data_q     <= '0;
            mode_q     <= '0;
            out_data_q <= '0;
            out_err_q  <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            data_q     <= data_d;
            mode_q     <= mode_d;
            out_data_q <= out_data_d;
            out_err_q  <= out_err_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == DONE);
    assign out_data  = out_data_q;
    assign out_err   = out_err_q;

endmodule

// File: tb/tb_multi_digit_code_converter.sv
// Scoreboard bench for multi_digit_code_converter: a 4-digit instance with a driven consumer
// and a 1-digit instance with a consumer that is always ready.
module tb_multi_digit_code_converter;

    typedef struct {
        logic [63:0] data;
        logic [15:0] err;
        time         t_acc;
    } exp_t;

    logic        clk;
    logic        rst_n;

    logic        in_valid, in_ready, out_valid, out_ready, busy;
    logic [15:0] in_data, out_data;
    logic [1:0]  in_mode;
    logic [3:0]  out_err;

    logic        in_valid1, in_ready1, out_valid1, busy1;
    logic [3:0]  in_data1, out_data1;
    logic [1:0]  in_mode1;
    logic [0:0]  out_err1;

    int   checks = 0;
    int   errors = 0;
    bit   rand_ready = 0;
    exp_t q4[$];
    exp_t q1[$];

    multi_digit_code_converter #(.DIGITS(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_mode(in_mode),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_err(out_err),
        .busy(busy)
    );

    multi_digit_code_converter #(.DIGITS(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1), .in_mode(in_mode1),
        .out_valid(out_valid1), .out_ready(1'b1), .out_data(out_data1), .out_err(out_err1),
        .busy(busy1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: digit-by-digit table/arithmetic straight from the code definitions.
    function automatic exp_t model(input logic [63:0] d, input int n, input logic [1:0] m);
        int   aiken[10] = '{0, 1, 2, 3, 4, 11, 12, 13, 14, 15};
        exp_t r;
        int   v, c;
        r.data  = '0;
        r.err   = '0;
        r.t_acc = 0;
        for (int i = 0; i < n; i++) begin
            v = int'((d >> (4 * i)) & 64'hF);
            if (v > 9) begin
                r.err[i] = 1'b1;
                c = 0;
            end else begin
                case (m)
                    2'd0:    c = v;
                    2'd1:    c = aiken[v];
                    2'd2:    c = v + 3;
                    default: c = v ^ (v / 2);
                endcase
            end
            r.data = r.data | (64'(c) << (4 * i));
        end
        return r;
    endfunction

    function automatic logic [15:0] rand_word(input int n);
        logic [15:0] w = '0;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) == 0) w[4*i +: 4] = 4'($urandom_range(10, 15));
            else                           w[4*i +: 4] = 4'($urandom_range(0, 9));
        end
        return w;
    endfunction

    // Offer a word to the 4-digit instance; push the expected result on acceptance.
    task automatic send(input logic [15:0] d, input logic [1:0] m,
                        input logic [15:0] exp_d, input logic [3:0] exp_e);
        exp_t e;
        bit   seen = 0;
        in_data  = d;
        in_mode  = m;
        in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready) begin
                seen = 1;
                break;
            end
        end
        check("send_in_ready_timeout", 64'(seen), 64'd1);
        @(posedge clk);
        e.data  = 64'(exp_d);
        e.err   = 16'(exp_e);
        e.t_acc = $time;
        q4.push_back(e);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid();
        bit seen = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1;
                break;
            end
        end
        check("wait_out_valid_timeout", 64'(seen), 64'd1);
    endtask

    task automatic wait_idle();
        bit seen = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready && q4.size() == 0) begin
                seen = 1;
                break;
            end
        end
        check("wait_idle_timeout", 64'(seen), 64'd1);
        @(posedge clk);
        #1;
    endtask

    // Random consumer backpressure, applied away from the driver's write slot.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
        end
    end

    // Monitor for the 4-digit instance.
    initial begin
        logic prev = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev = 1'b0;
            end else begin
                if (out_valid && !prev) begin
                    if (q4.size() == 0) check("d4_unexpected_valid", 64'd1, 64'd0);
                    else check("d4_latency", 64'($time - 5 - q4[0].t_acc), 64'd40);
                end
                if (out_valid && out_ready && q4.size() > 0) begin
                    e = q4.pop_front();
                    check("d4_out_data", 64'(out_data), e.data);
                    check("d4_out_err", 64'(out_err), 64'(e.err));
                end
                prev = out_valid;
            end
        end
    end

    // Monitor for the 1-digit instance (consumer always ready).
    initial begin
        logic prev = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev = 1'b0;
            end else begin
                if (out_valid1 && !prev) begin
                    if (q1.size() == 0) begin
                        check("d1_unexpected_valid", 64'd1, 64'd0);
                    end else begin
                        e = q1.pop_front();
                        check("d1_latency", 64'($time - 5 - e.t_acc), 64'd10);
                        check("d1_out_data", 64'(out_data1), e.data);
                        check("d1_out_err", 64'(out_err1), 64'(e.err));
                    end
                end
                prev = out_valid1;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t        e;
        logic [15:0] w;
        logic [1:0]  m;
        time         t_prev, t_now;
        bit          seen;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_mode   = '0;
        out_ready = 1'b1;
        in_valid1 = 1'b0;
        in_data1  = '0;
        in_mode1  = '0;

        #12;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_err", 64'(out_err), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        #6 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Known conversions.
        send(16'h5789, 2'd1, 16'hBDEF, 4'b0000);
        wait_idle();
        send(16'h0912, 2'd2, 16'h3C45, 4'b0000);
        wait_idle();
        send(16'h0359, 2'd3, 16'h027D, 4'b0000);
        wait_idle();
        send(16'h1A3F, 2'd0, 16'h1030, 4'b0101);
        wait_idle();

        // Stall in DONE while a different word is offered.
        out_ready = 1'b0;
        send(16'h1234, 2'd0, 16'h1234, 4'b0000);
        wait_valid();
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_data  = 16'h9999;
        in_mode  = 2'd3;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_out_data", 64'(out_data), 64'h1234);
            check("stall_in_ready", 64'(in_ready), 64'd0);
            check("stall_out_valid", 64'(out_valid), 64'd1);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("release_in_ready", 64'(in_ready), 64'd1);
        check("release_out_valid", 64'(out_valid), 64'd0);
        in_valid = 1'b0;
        @(posedge clk);
        #1;

        // Abort a word with reset after two CONV edges.
        send(16'h4321, 2'd2, 16'h7654, 4'b0000);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", 64'(out_valid), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_out_data", 64'(out_data), 64'd0);
        check("abort_out_err", 64'(out_err), 64'd0);
        check("abort_in_ready", 64'(in_ready), 64'd1);
        void'(q4.pop_back());
        #1 rst_n = 1'b1;
        e = model(64'h0864, 4, 2'd3);
        send(16'h0864, 2'd3, e.data[15:0], e.err[3:0]);
        wait_idle();

        // Random words, modes, gaps and backpressure.
        rand_ready = 1;
        for (int k = 0; k < 40; k++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            w = rand_word(4);
            m = 2'($urandom_range(0, 3));
            e = model(64'(w), 4, m);
            send(w, m, e.data[15:0], e.err[3:0]);
        end
        rand_ready = 0;
        out_ready  = 1'b1;
        wait_idle();

        // One-digit instance: back-to-back words, one accepted every 3 cycles.
        in_valid1 = 1'b1;
        t_prev    = 0;
        for (int k = 0; k < 20; k++) begin
            in_data1 = 4'(rand_word(1));
            in_mode1 = 2'($urandom_range(0, 3));
            seen = 0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (in_ready1) begin
                    seen = 1;
                    break;
                end
            end
            check("d1_in_ready_timeout", 64'(seen), 64'd1);
            @(posedge clk);
            t_now   = $time;
            e       = model(64'(in_data1), 1, in_mode1);
            e.t_acc = t_now;
            q1.push_back(e);
            if (k > 0) check("d1_throughput", 64'(t_now - t_prev), 64'd30);
            t_prev = t_now;
            #1;
        end
        in_valid1 = 1'b0;

        seen = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (q1.size() == 0 && q4.size() == 0) begin
                seen = 1;
                break;
            end
        end
        check("drain_scoreboard", 64'(seen), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
